// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants and colour types.
// Imported by the pixel compositor and its priority mux.
package vga_pkg;

  localparam int RGB_W     = 12;
  localparam int COORD_W   = 10;
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int REFRESH_Y = 481;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t RGB_BLACK = '0;

endpackage

// File: rtl/priority_mux.sv
// Lowest-index-wins layer select returning colour and hit flag.
// Optional colour key (PIXCOMP_COLORKEY_EN) makes KEY_RGB transparent.
module priority_mux
  import vga_pkg::*;
#(
  parameter int              NUM_LAYERS = 4,
  parameter int              RGB_W      = 12,
  parameter logic [RGB_W-1:0] KEY_RGB   = 'hF0F
) (
  input  logic [NUM_LAYERS-1:0]       on,
  input  logic [NUM_LAYERS*RGB_W-1:0] rgb_in,
  output logic [RGB_W-1:0]            win_rgb,
  output logic                        hit
);

`ifdef PIXCOMP_COLORKEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic [NUM_LAYERS-1:0] eff_on;

  // Per-layer visibility after optional colour-key knockout
  always_comb begin
    eff_on = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eff_on[i] = on[i] &&
        !(KEY_EN &&
          (rgb_in[i*RGB_W +: RGB_W] == KEY_RGB));
    end
  end

  // Scan high to low so the lowest visible index wins
  always_comb begin
    win_rgb = RGB_W'(RGB_BLACK);
    hit     = 1'b0;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (eff_on[i]) begin
        win_rgb = rgb_in[i*RGB_W +: RGB_W];
        hit     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_compositor.sv
// Fixed-priority layer compositor with matched pipeline,
// refresh tick, frame-latched enables (PIXCOMP_COLORKEY_EN opt).
module pixel_compositor #(
  parameter int NUM_LAYERS  = 4,
  parameter int RGB_W       = vga_pkg::RGB_W,
  parameter int COORD_W     = vga_pkg::COORD_W,
  parameter int LATENCY     = 3,
  parameter int REFRESH_Y   = vga_pkg::REFRESH_Y,
  parameter int FRAME_CNT_W = 8,
  parameter logic [RGB_W-1:0] KEY_RGB = RGB_W'(12'hF0F)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        video_on,
  input  logic [COORD_W-1:0]          x,
  input  logic [COORD_W-1:0]          y,
  input  logic [NUM_LAYERS-1:0]       layer_on,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_en_req,
  input  logic [RGB_W-1:0]            bg_rgb,
  output logic [RGB_W-1:0]            rgb,
  output logic                        video_on_out,
  output logic                        refresh_tick,
  output logic [NUM_LAYERS-1:0]       layer_en_active,
  output logic [FRAME_CNT_W-1:0]      frame_count
);

  import vga_pkg::*;

  localparam logic [COORD_W-1:0] REF_Y =
    COORD_W'(REFRESH_Y);

  logic                        s1_von;
  logic [NUM_LAYERS-1:0]       s1_on;
  logic [NUM_LAYERS*RGB_W-1:0] s1_rgb;
  logic [RGB_W-1:0]            s1_bg;

  logic [RGB_W-1:0] mux_rgb;
  logic             mux_hit;

  logic [RGB_W-1:0] pipe_rgb [2:LATENCY];
  logic             pipe_von [2:LATENCY];

  logic                   match;
  logic                   match_q;
  logic                   tick_q;
  logic [NUM_LAYERS-1:0]  en_q;
  logic [FRAME_CNT_W-1:0] frame_q;

  // Stage 1: sample inputs with enables gated in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_von <= 1'b0;
      s1_on  <= '0;
      s1_rgb <= '0;
      s1_bg  <= '0;
    end else begin
      s1_von <= video_on;
      s1_on  <= layer_on & en_q;
      s1_rgb <= layer_rgb;
      s1_bg  <= bg_rgb;
    end
  end

  priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .RGB_W      (RGB_W),
    .KEY_RGB    (KEY_RGB)
  ) u_mux (
    .on      (s1_on),
    .rgb_in  (s1_rgb),
    .win_rgb (mux_rgb),
    .hit     (mux_hit)
  );

  // Stage 2 select, then plain delay up to LATENCY
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 2; k <= LATENCY; k++) begin
        pipe_rgb[k] <= '0;
        pipe_von[k] <= 1'b0;
      end
    end else begin
      pipe_von[2] <= s1_von;
      if (!s1_von)
        pipe_rgb[2] <= RGB_W'(RGB_BLACK);
      else if (mux_hit)
        pipe_rgb[2] <= mux_rgb;
      else
        pipe_rgb[2] <= s1_bg;
      for (int k = 3; k <= LATENCY; k++) begin
        pipe_rgb[k] <= pipe_rgb[k-1];
        pipe_von[k] <= pipe_von[k-1];
      end
    end
  end

  assign match = (y == REF_Y) && (x == '0);

  // Rising-edge detect on match; match_q resets high so a
  // release in the middle of the match window stays silent
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      match_q <= match;
      tick_q  <= match & ~match_q;
    end
  end

  // Frame boundary: latch enables and count frames
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q    <= '1;
      frame_q <= '0;
    end else if (tick_q) begin
      en_q    <= layer_en_req;
      frame_q <= frame_q + FRAME_CNT_W'(1);
    end
  end

  assign rgb             = pipe_rgb[LATENCY];
  assign video_on_out    = pipe_von[LATENCY];
  assign refresh_tick    = tick_q;
  assign layer_en_active = en_q;
  assign frame_count     = frame_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Scoreboard bench for pixel_compositor: stimulus pushes
// expected pixels, a monitor pops and compares on their due cycle.
module tb_pixel_compositor;

  localparam int NL  = 4;
  localparam int W   = 12;
  localparam int CW  = 10;
  localparam int LAT = 3;

`ifdef PIXCOMP_COLORKEY_EN
  localparam logic [W-1:0] KEY_EXP = 12'h0F0;
`else
  localparam logic [W-1:0] KEY_EXP = 12'hF0F;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            video_on = 1'b0;
  logic [CW-1:0]   x = 10'd5;
  logic [CW-1:0]   y = 10'd0;
  logic [NL-1:0]   layer_on = '0;
  logic [NL*W-1:0] layer_rgb = '0;
  logic [NL-1:0]   layer_en_req = '1;
  logic [W-1:0]    bg_rgb = '0;
  logic [W-1:0]    rgb;
  logic            video_on_out;
  logic            refresh_tick;
  logic [NL-1:0]   layer_en_active;
  logic [7:0]      frame_count;

  pixel_compositor dut (
    .clk             (clk),
    .reset           (reset),
    .video_on        (video_on),
    .x               (x),
    .y               (y),
    .layer_on        (layer_on),
    .layer_rgb       (layer_rgb),
    .layer_en_req    (layer_en_req),
    .bg_rgb          (bg_rgb),
    .rgb             (rgb),
    .video_on_out    (video_on_out),
    .refresh_tick    (refresh_tick),
    .layer_en_active (layer_en_active),
    .frame_count     (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic         von;
    logic [W-1:0] rgb;
    int           id;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   pid = 0;

  // Monitor: compare every entry due on this cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sbq.size()-1; i >= 0; i--) begin
        if (sbq[i].due == cyc) begin
          vectors++;
          if (rgb !== sbq[i].rgb ||
              video_on_out !== sbq[i].von) begin
            miscompares++;
            $display("FAIL pix%0d cyc %0d: rgb=%h von=%b want rgb=%h von=%b",
              sbq[i].id, cyc, rgb, video_on_out,
              sbq[i].rgb, sbq[i].von);
          end
          sbq.delete(i);
        end else if (sbq[i].due < cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL pix%0d missed due %0d: got cyc %0d want on time",
            sbq[i].id, sbq[i].due, cyc);
          sbq.delete(i);
        end
      end
    end
  end

  task automatic push(input int lag, input logic v,
                      input logic [W-1:0] c);
    exp_t e;
    pid++;
    e.due = cyc + lag;
    e.von = v;
    e.rgb = c;
    e.id  = pid;
    sbq.push_back(e);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_l(input int i, input logic [W-1:0] c);
    layer_rgb[i*W +: W] = c;
  endtask

  task automatic pulse_match();
    x = '0;
    y = 10'd481;
    nxt();
    x = 10'd5;
    y = '0;
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] pat;
    video_on = 1'b1;
    layer_on = 4'b0011;
    set_l(0, 12'hF00);
    set_l(1, 12'h0F0);
    nxt();
    nxt();
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_von", 32'(video_on_out), 32'h0);
    chk("rst_tick", 32'(refresh_tick), 32'h0);
    chk("rst_en", 32'(layer_en_active), 32'hF);
    chk("rst_frame", 32'(frame_count), 32'h0);

    // First-pixel latency
    reset = 1'b1;
    push(2, 1'b0, 12'h000);
    push(LAT, 1'b1, 12'hF00);
    nxt();
    repeat (2) begin
      push(LAT, 1'b1, 12'hF00);
      nxt();
    end

    // Background then blanking
    layer_on = 4'b0000;
    bg_rgb = 12'h00F;
    push(LAT, 1'b1, 12'h00F);
    nxt();
    push(LAT, 1'b1, 12'h00F);
    nxt();
    video_on = 1'b0;
    push(2, 1'b1, 12'h00F);
    push(LAT, 1'b0, 12'h000);
    nxt();
    layer_on = 4'b0011;
    push(LAT, 1'b0, 12'h000);
    nxt();
    video_on = 1'b1;
    layer_on = 4'b0100;
    set_l(2, 12'h123);
    push(LAT, 1'b1, 12'h123);
    nxt();
    layer_on = 4'b1000;
    set_l(3, 12'hABC);
    push(LAT, 1'b1, 12'hABC);
    nxt();
    layer_on = 4'b1110;
    push(LAT, 1'b1, 12'h0F0);
    nxt();

    // Refresh tick held for 4 clocks
    x = '0;
    y = 10'd481;
    pat = '0;
    repeat (4) begin
      nxt();
      pat = {pat[2:0], refresh_tick};
    end
    chk("tick_pat", 32'(pat), 32'h8);
    chk("frame_1", 32'(frame_count), 32'h1);
    x = 10'd5;
    y = '0;
    nxt();
    for (int i = 0; i < 254; i++) pulse_match();
    chk("frame_255", 32'(frame_count), 32'hFF);
    pulse_match();
    chk("frame_wrap", 32'(frame_count), 32'h0);

    // Enable request applied only at the tick
    layer_on = 4'b0011;
    set_l(0, 12'hF00);
    set_l(1, 12'h0F0);
    layer_en_req = 4'b1110;
    repeat (2) begin
      push(LAT, 1'b1, 12'hF00);
      nxt();
    end
    chk("en_hold", 32'(layer_en_active), 32'hF);
    x = '0;
    y = 10'd481;
    push(LAT, 1'b1, 12'hF00);
    nxt();
    x = 10'd5;
    y = '0;
    chk("en_tick", 32'(refresh_tick), 32'h1);
    chk("en_tick_old", 32'(layer_en_active), 32'hF);
    push(LAT, 1'b1, 12'hF00);
    nxt();
    chk("en_new", 32'(layer_en_active), 32'hE);
    push(LAT, 1'b1, 12'h0F0);
    nxt();
    push(LAT, 1'b1, 12'h0F0);
    nxt();
    layer_en_req = 4'b1111;
    pulse_match();
    repeat (4) nxt();
    chk("en_restore", 32'(layer_en_active), 32'hF);

    // Colour key
    set_l(0, 12'hF0F);
    push(LAT, 1'b1, KEY_EXP);
    nxt();
    push(LAT, 1'b1, KEY_EXP);
    nxt();

    // Reset while match is high
    repeat (5) nxt();
    x = '0;
    y = 10'd481;
    nxt();
    reset = 1'b0;
    #1;
    chk("mid_tick", 32'(refresh_tick), 32'h0);
    chk("mid_frame", 32'(frame_count), 32'h0);
    chk("mid_rgb", 32'(rgb), 32'h0);
    chk("mid_von", 32'(video_on_out), 32'h0);
    nxt();
    nxt();
    reset = 1'b1;
    pat = '0;
    repeat (3) begin
      nxt();
      pat = {pat[2:0], refresh_tick};
    end
    chk("rel_notick", 32'(pat), 32'h0);
    chk("rel_frame", 32'(frame_count), 32'h0);
    x = 10'd5;
    y = '0;
    nxt();
    x = '0;
    y = 10'd481;
    nxt();
    chk("next_tick", 32'(refresh_tick), 32'h1);
    x = 10'd5;
    y = '0;
    nxt();
    chk("next_frame", 32'(frame_count), 32'h1);

    repeat (5) nxt();
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule
